// File: rtl/rx_deframer.sv
// Serial frame receiver: hunts for the ones header, destuffs, reassembles the
// device ID and payload, checks parity/stuffing/trailer, hands words to the host.
module rx_deframer #(
  parameter int unsigned HDR_ONES  = 5,
  parameter int unsigned STUFF_RUN = 4,
  parameter int unsigned TRL_ZEROS = 5
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        sd_in,
  input  logic        rx_ack,
  output logic [39:0] dout,
  output logic [7:0]  src_id,
  output logic        rx_valid,
  output logic        parity_err,
  output logic        frame_err,
  output logic        overrun
);

  typedef enum logic [1:0] {HUNT, DATA, PAR, TRL} state_t;

  state_t      state, state_n;
  logic [2:0]  run, run_n, run_acc;
  logic [5:0]  bcnt, bcnt_n;
  logic [47:0] sh, sh_n;
  logic        par, par_n;
  logic        p_rx, p_rx_n;
  logic [39:0] dout_n;
  logic [7:0]  src_n;
  logic        valid_n, perr_n, ferr_n, ovr_n;
  logic        stuff_slot;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= HUNT;
      run        <= '0;
      bcnt       <= '0;
      sh         <= '0;
      par        <= 1'b0;
      p_rx       <= 1'b0;
      dout       <= '0;
      src_id     <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_n;
      run        <= run_n;
      bcnt       <= bcnt_n;
      sh         <= sh_n;
      par        <= par_n;
      p_rx       <= p_rx_n;
      dout       <= dout_n;
      src_id     <= src_n;
      rx_valid   <= valid_n;
      parity_err <= perr_n;
      frame_err  <= ferr_n;
      overrun    <= ovr_n;
    end
  end

  always_comb begin
    state_n    = state;
    run_n      = run;
    bcnt_n     = bcnt;
    sh_n       = sh;
    par_n      = par;
    p_rx_n     = p_rx;
    dout_n     = dout;
    src_n      = src_id;
    valid_n    = rx_valid;
    perr_n     = 1'b0;
    ferr_n     = 1'b0;
    ovr_n      = 1'b0;
    stuff_slot = (run == 3'(STUFF_RUN));
    run_acc    = sd_in ? run + 3'd1 : 3'd0;

    if (rx_ack && rx_valid)
      valid_n = 1'b0;

    if (state == HUNT) begin
      run_n = run_acc;
      if (run_acc == 3'(HDR_ONES)) begin
        state_n = DATA;
        run_n   = '0;
        bcnt_n  = '0;
        par_n   = 1'b0;
      end
    end else if (stuff_slot) begin
      run_n = '0;
      if (sd_in) begin
        ferr_n  = 1'b1;
        state_n = HUNT;
      end
    end else begin
      run_n = run_acc;
      if (state == DATA) begin
        // Shift in at the top so line bit k lands at sh[k] after 48 bits.
        sh_n  = {sd_in, sh[47:1]};
        par_n = par ^ sd_in;
        if (bcnt == 6'd47) begin
          state_n = PAR;
          bcnt_n  = '0;
        end else begin
          bcnt_n = bcnt + 6'd1;
        end
      end else if (state == PAR) begin
        p_rx_n  = sd_in;
        state_n = TRL;
        bcnt_n  = '0;
      end else begin
        if (sd_in) begin
          ferr_n  = 1'b1;
          state_n = HUNT;
          run_n   = '0;
        end else if (bcnt == 6'(TRL_ZEROS - 1)) begin
          state_n = HUNT;
          run_n   = '0;
          if (p_rx != par) begin
            perr_n = 1'b1;
          end else begin
            dout_n  = {sh[15:8], sh[47:16]};
            src_n   = sh[7:0];
            valid_n = 1'b1;
            ovr_n   = rx_valid && !rx_ack;
          end
        end else begin
          bcnt_n = bcnt + 6'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_deframer.sv
// Directed bench for rx_deframer: a bench-side framer builds stuffed line bit
// streams; checks use immediate assertions against hand-derived expectations.
module tb_rx_deframer;

  logic        clk = 1'b0;
  logic        clr, sd_in, rx_ack;
  logic [39:0] dout;
  logic [7:0]  src_id;
  logic        rx_valid, parity_err, frame_err, overrun;

  int checks   = 0;
  int failures = 0;
  int fe_cnt   = 0;
  int pe_cnt   = 0;
  int ov_cnt   = 0;
  bit bitq[$];

  rx_deframer #(.HDR_ONES(5), .STUFF_RUN(4), .TRL_ZEROS(5)) dut (
    .clk(clk), .clr(clr), .sd_in(sd_in), .rx_ack(rx_ack),
    .dout(dout), .src_id(src_id), .rx_valid(rx_valid),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err)  fe_cnt++;
    if (parity_err) pe_cnt++;
    if (overrun)    ov_cnt++;
  end

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line order: header, id[0..7], din[32..39], din[0..31], P, trailer; stuff after 4 ones.
  task automatic build(input logic [7:0] id, input logic [39:0] din, input bit flip);
    bit raw[$];
    int r;
    bitq.delete();
    repeat (5) bitq.push_back(1'b1);
    for (int i = 0; i < 8; i++)   raw.push_back(id[i]);
    for (int i = 32; i < 40; i++) raw.push_back(din[i]);
    for (int i = 0; i < 32; i++)  raw.push_back(din[i]);
    raw.push_back((^{id, din}) ^ flip);
    repeat (5) raw.push_back(1'b0);
    r = 0;
    foreach (raw[i]) begin
      bitq.push_back(raw[i]);
      r = raw[i] ? r + 1 : 0;
      if (r == 4) begin
        bitq.push_back(1'b0);
        r = 0;
      end
    end
  endtask

  task automatic send_bits(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      sd_in = bitq[i];
      tick();
    end
    sd_in = 1'b0;
  endtask

  task automatic send_frame(input bit ack_last);
    send_bits(0, bitq.size() - 2);
    rx_ack = ack_last;
    sd_in  = bitq[bitq.size() - 1];
    tick();
    rx_ack = 1'b0;
    sd_in  = 1'b0;
  endtask

  task automatic ack_word();
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
  endtask

  initial begin
    sd_in  = 1'b0;
    rx_ack = 1'b0;
    clr    = 1'b1;
    tick();
    tick();
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_dout", dout, 40'h0);
    chk("rst_src", src_id, 8'h0);
    chk("rst_errs", {parity_err, frame_err, overrun}, 3'b000);
    clr = 1'b0;
    tick();

    // All-zero frame: completion on the edge sampling line bit 58.
    build(8'h00, 40'h0, 1'b0);
    send_bits(0, 57);
    chk("t1_valid_early", rx_valid, 1'b0);
    send_bits(58, 58);
    chk("t1_valid", rx_valid, 1'b1);
    chk("t1_dout", dout, 40'h0);
    chk("t1_src", src_id, 8'h00);
    ack_word();
    chk("t1_ack", rx_valid, 1'b0);

    // All-ones frame: 12 stuffed zeros, completion at line bit 70.
    build(8'hFF, 40'hFF_FFFF_FFFF, 1'b0);
    send_bits(0, 69);
    chk("t2_valid_early", rx_valid, 1'b0);
    send_bits(70, 70);
    chk("t2_valid", rx_valid, 1'b1);
    chk("t2_dout", dout, 40'hFF_FFFF_FFFF);
    chk("t2_src", src_id, 8'hFF);
    ack_word();

    // Mixed frame, ack next cycle, then back-to-back frame after one idle.
    build(8'hA5, 40'h12_3456_789A, 1'b0);
    send_frame(1'b0);
    chk("t3_valid", rx_valid, 1'b1);
    chk("t3_dout", dout, 40'h12_3456_789A);
    chk("t3_src", src_id, 8'hA5);
    ack_word();
    chk("t3_ack", rx_valid, 1'b0);
    build(8'h3C, 40'hFE_DCBA_9876, 1'b0);
    send_frame(1'b0);
    chk("t3b_valid", rx_valid, 1'b1);
    chk("t3b_dout", dout, 40'hFE_DCBA_9876);
    chk("t3b_src", src_id, 8'h3C);
    chk("t3_no_errs", fe_cnt + pe_cnt + ov_cnt, 48'd0);
    ack_word();

    // Parity flipped: discarded, outputs keep the previous word.
    build(8'hA5, 40'h12_3456_789A, 1'b1);
    send_frame(1'b0);
    chk("t4_perr", parity_err, 1'b1);
    chk("t4_ferr", frame_err, 1'b0);
    chk("t4_valid", rx_valid, 1'b0);
    chk("t4_dout_held", dout, 40'hFE_DCBA_9876);
    tick();
    chk("t4_perr_end", parity_err, 1'b0);
    repeat (3) tick();
    chk("t4_perr_cnt", pe_cnt, 48'd1);
    build(8'hA5, 40'h12_3456_789A, 1'b0);
    send_frame(1'b0);
    chk("t4_good_valid", rx_valid, 1'b1);
    chk("t4_good_dout", dout, 40'h12_3456_789A);
    ack_word();

    // A 1 in the first stuff slot (line bit 9).
    fe_cnt = 0;
    build(8'hFF, 40'hFF_FFFF_FFFF, 1'b0);
    bitq[9] = 1'b1;
    send_bits(0, 9);
    chk("t5a_ferr", frame_err, 1'b1);
    repeat (8) tick();
    chk("t5a_ferr_cnt", fe_cnt, 48'd1);
    chk("t5a_valid", rx_valid, 1'b0);

    // A 1 in the third trailer bit.
    fe_cnt = 0;
    build(8'h00, 40'h0, 1'b0);
    bitq[56] = 1'b1;
    send_bits(0, 56);
    chk("t5b_ferr", frame_err, 1'b1);
    chk("t5b_perr", parity_err, 1'b0);
    repeat (8) tick();
    chk("t5b_ferr_cnt", fe_cnt, 48'd1);
    chk("t5b_valid", rx_valid, 1'b0);

    // Async clear mid-DATA with a word held.
    build(8'h5A, 40'h01_2345_6789, 1'b0);
    send_frame(1'b0);
    chk("t5c_pre_valid", rx_valid, 1'b1);
    chk("t5c_pre_dout", dout, 40'h01_2345_6789);
    build(8'hC3, 40'hAA_5555_AAAA, 1'b0);
    send_bits(0, 19);
    #2 clr = 1'b1;
    #1;
    chk("t5c_clr_valid", rx_valid, 1'b0);
    chk("t5c_clr_dout", dout, 40'h0);
    chk("t5c_clr_src", src_id, 8'h0);
    tick();
    clr = 1'b0;
    repeat (3) tick();
    send_frame(1'b0);
    chk("t5c_valid", rx_valid, 1'b1);
    chk("t5c_dout", dout, 40'hAA_5555_AAAA);
    chk("t5c_src", src_id, 8'hC3);
    ack_word();

    // Overrun without ack, then completion coinciding with ack.
    ov_cnt = 0;
    build(8'h11, 40'h11_1111_1111, 1'b0);
    send_frame(1'b0);
    chk("t6_valid", rx_valid, 1'b1);
    chk("t6_ovr0", overrun, 1'b0);
    tick();
    build(8'h22, 40'h22_2222_2222, 1'b0);
    send_frame(1'b0);
    chk("t6_ovr", overrun, 1'b1);
    chk("t6_valid2", rx_valid, 1'b1);
    chk("t6_dout2", dout, 40'h22_2222_2222);
    chk("t6_src2", src_id, 8'h22);
    tick();
    chk("t6_ovr_end", overrun, 1'b0);
    build(8'h33, 40'h33_3333_3333, 1'b0);
    send_frame(1'b1);
    chk("t6_ack_ovr", overrun, 1'b0);
    chk("t6_ack_valid", rx_valid, 1'b1);
    chk("t6_ack_dout", dout, 40'h33_3333_3333);
    repeat (3) tick();
    chk("t6_ovr_cnt", ov_cnt, 48'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_deframer.md
Name: rx_deframer

Overview:
Serial frame receiver and the receive end of the tx serial link. It samples `sd_in` once per `clk`, detects the 5-ones header, removes stuffed zeros, and reassembles the 8-bit device ID and 40-bit payload. It checks parity, stuff rule and trailer, then presents the word to the host through a valid/ack holding register. Sits at the coprocessor's serial input, opposite a tx instance on the same clock.

Parameters:
HDR_ONES, 5, consecutive ones forming the header.
STUFF_RUN, 4, run of ones after which one stuffed 0 follows.
TRL_ZEROS, 5, trailer zero count.

Ports:
clk  in  1  clock; `sd_in` sampled on posedge
clr  in  1  reset, asynchronous, active-high
sd_in  in  1  serial line, synchronous to clk, idles 0
rx_ack  in  1  host consumed current word
dout  out  40  received payload (tx din[39:0])
src_id  out  8  received device ID
rx_valid  out  1  dout/src_id hold an unconsumed word
parity_err  out  1  1-cycle pulse, frame discarded on parity mismatch
frame_err  out  1  1-cycle pulse, stuff or trailer violation
overrun  out  1  1-cycle pulse, unconsumed word overwritten

Behaviour:
- Reset: clr asserted forces all outputs 0, state HUNT, all counters 0; async, mid-frame included. Any partial frame is lost.
- Line order, unstuffed, first bit first:
  - 5 ones (header).
  - id[0..7].
  - din[32..39].
  - din[0..31].
  - P = XOR of those 48 bits (even parity).
  - 5 zeros (trailer).
- Stuffing: from the first id bit through the last trailer bit, after 4 consecutive ones the next line bit is a stuffed 0. It is discarded and the ones-run counter is cleared. The header is never stuffed.
- FSM states HUNT, DATA, PAR, TRL. A 3-bit ones-run counter `run` and a 6-bit bit counter `bcnt` are shared across states.
- HUNT:
  - sd_in=1 increments run; sd_in=0 clears it.
  - When run reaches 5, go to DATA with run=0 and bcnt=0.
- DATA, PAR and TRL destuff rule:
  - If run==4, the sampled bit is a stuff slot.
  - 0: discard, run=0.
  - 1: pulse frame_err, return to HUNT with run=0.
  - Otherwise the bit is accepted, and run increments on 1 and clears on 0.
- DATA:
  - Accepted bits shift into a 48-bit register in line order and XOR into the running parity.
  - After bcnt reaches 47, go to PAR.
- PAR: store the accepted bit as P_rx, go to TRL with bcnt=0.
- TRL:
  - An accepted 1 pulses frame_err and returns to HUNT.
  - After 5 accepted zeros, return to HUNT and complete the frame.
- Completion, on the edge sampling the 5th trailer zero:
  - If P_rx != running parity: pulse parity_err, discard the frame, leave outputs unchanged.
  - Otherwise: load dout={d[39:32],d[31:0]} and src_id, and set rx_valid=1.
- Latency: with header bit 1 sampled at edge E0 and S stuffed bits in the frame, rx_valid is visible after edge E0+58+S.
- Handshake: rx_ack=1 at a posedge while rx_valid=1 clears rx_valid. rx_ack while rx_valid=0 is ignored.
- Completion while rx_valid=1 and no rx_ack that cycle: new word overwrites, rx_valid stays 1, overrun pulses.
- Completion with rx_ack in the same cycle: new word loads, rx_valid stays 1, no overrun.
- Error pulses are mutually exclusive per frame and last exactly one cycle.
- Back-to-back frames: the tx inserts at least one idle 0, so HUNT resynchronises. A post-stuffing payload never contains 5 ones, so the header is unique and resync after reset or error occurs at the next header.

Test Plan:
1. id=8'h00, din=40'h0: ones header then zeros -> rx_valid after E0+58, dout=0, src_id=0, no errors.
2. id=8'hFF, din=40'hFF_FFFF_FFFF: 12 stuffed zeros, P=0 -> rx_valid after E0+70, dout=40'hFF_FFFF_FFFF, src_id=8'hFF.
3. id=8'hA5, din=40'h12_3456_789A from a live tx instance, then rx_ack one cycle later -> outputs match, rx_valid 1 then cleared after ack; a second back-to-back frame received correctly.
4. Same frame with parity bit flipped -> parity_err single pulse, rx_valid stays 0; a following good frame is received.
5. Force a 1 in a stuff slot, and separately a 1 in trailer bit 3 -> frame_err pulse, HUNT. Assert clr mid-DATA -> all outputs 0; next frame received normally.
6. Two good frames, no ack -> overrun pulse, dout holds the second word. Repeat with rx_ack on the completion cycle -> no overrun, rx_valid stays 1.
